fir_filter_mc: RTL and testbench

// Parametrised, multi-channel, time-multiplexed FIR filter with a runtime-loadable coefficient bank.

---
 rtl/fir_filter_mc_pkg.sv | 34 +++
 rtl/fir_filter_mc_if.sv | 33 +++
 rtl/fir_coef_bank.sv | 34 +++
 rtl/fir_filter_mc.sv | 155 +++++++++++++++
 tb/tb_fir_filter_mc.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_filter_mc_pkg.sv
// Shared FSM state type and arithmetic helpers for the multi-channel FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  clip;
    wide_t val;
  } rsat_t;

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned cw,
                                        input int unsigned nt);
    return dw + cw + $clog2(nt);
  endfunction

  // Round half up, then clip to a signed dw-bit range; clip flags any saturation.
  function automatic rsat_t round_sat(input wide_t acc, input int unsigned frac,
                                      input int unsigned dw);
    wide_t r;
    wide_t hi;
    wide_t lo;
    rsat_t res;
    r        = (acc + (wide_t'(1) <<< (frac - 1))) >>> frac;
    hi       = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo       = -(wide_t'(1) <<< (dw - 1));
    res.clip = (r > hi) || (r < lo);
    res.val  = (r > hi) ? hi : ((r < lo) ? lo : r);
    return res;
  endfunction

endpackage

// File: rtl/fir_filter_mc_if.sv
// Sample, coefficient-load and result signals of the multi-channel FIR.
interface fir_filter_mc_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned NUM_TAPS   = 29,
  parameter int unsigned NUM_CH     = 2
);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ADDR_W = $clog2(NUM_TAPS);

  logic signed [DATA_WIDTH-1:0] audio_in;
  logic [CH_W-1:0]              ch_in;
  logic                         valid_in;
  logic                         ready_out;
  logic                         coef_we;
  logic [ADDR_W-1:0]            coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         coef_err;
  logic signed [DATA_WIDTH-1:0] filtered_audio;
  logic [CH_W-1:0]              ch_out;
  logic                         data_ready;
  logic                         sat_out;

  modport slave (
    input  audio_in, ch_in, valid_in, coef_we, coef_addr, coef_data,
    output ready_out, coef_err, filtered_audio, ch_out, data_ready, sat_out
  );

  modport master (
    output audio_in, ch_in, valid_in, coef_we, coef_addr, coef_data,
    input  ready_out, coef_err, filtered_audio, ch_out, data_ready, sat_out
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient register file: identity response out of reset, one write port, async read.
module fir_coef_bank #(
  parameter int unsigned NUM_TAPS   = 29,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned COEF_FRAC  = 14
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          we,
  input  logic [$clog2(NUM_TAPS)-1:0]   waddr,
  input  logic signed [COEF_WIDTH-1:0]  wdata,
  input  logic [$clog2(NUM_TAPS)-1:0]   raddr,
  output logic signed [COEF_WIDTH-1:0]  rdata_c
);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << COEF_FRAC);

  logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_d [NUM_TAPS];

  always_comb begin
    coef_d = coef_q;
    if (we && (32'(waddr) < NUM_TAPS)) coef_d[waddr] = wdata;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= (i == 0) ? COEF_ONE : '0;
    end else begin
      coef_q <= coef_d;
    end
  end

  assign rdata_c = coef_q[raddr];
endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one MAC per clock, circular per-channel delay lines,
// shared runtime-loadable coefficients, rounded/saturated channel-tagged output.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = 29,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned COEF_FRAC  = 14,
  parameter int unsigned NUM_CH     = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  fir_filter_mc_if.slave  bus
);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ADDR_W = $clog2(NUM_TAPS);
  localparam int unsigned ACC_W  = acc_w(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;

  fir_state_t                   state_q, state_d;
  logic [ADDR_W-1:0]            k_q, k_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [ADDR_W-1:0]            wptr_q [NUM_CH];
  logic [ADDR_W-1:0]            wptr_d [NUM_CH];
  logic signed [DATA_WIDTH-1:0] delay_mem [NUM_CH][NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] filt_q, filt_d;
  logic [CH_W-1:0]              ch_out_q, ch_out_d;
  logic                         ready_q, ready_d;
  logic                         drdy_q, drdy_d;
  logic                         sat_q, sat_d;
  logic                         cerr_q, cerr_d;

  logic                         coef_we_c;
  logic                         dly_we_c;
  logic [ADDR_W-1:0]            wp_c;
  logic [ADDR_W-1:0]            rd_idx_c;
  logic signed [COEF_WIDTH-1:0] coef_rd_c;
  logic signed [DATA_WIDTH-1:0] x_rd_c;
  logic signed [PROD_W-1:0]     prod_c;
  rsat_t                        rs_c;
  logic                         unused_rs_c;

  fir_coef_bank #(
    .NUM_TAPS   (NUM_TAPS),
    .COEF_WIDTH (COEF_WIDTH),
    .COEF_FRAC  (COEF_FRAC)
  ) u_coef_bank (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .we      (coef_we_c),
    .waddr   (bus.coef_addr),
    .wdata   (bus.coef_data),
    .raddr   (k_q),
    .rdata_c (coef_rd_c)
  );

  // Tap k reads the sample written k acceptances ago: (wptr - k) mod NUM_TAPS.
  always_comb begin
    wp_c     = wptr_q[ch_q];
    rd_idx_c = (wp_c >= k_q) ? (wp_c - k_q) : (ADDR_W'(NUM_TAPS) + wp_c - k_q);
    x_rd_c   = delay_mem[ch_q][rd_idx_c];
    prod_c   = coef_rd_c * x_rd_c;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    wptr_d    = wptr_q;
    filt_d    = filt_q;
    ch_out_d  = ch_out_q;
    drdy_d    = 1'b0;
    sat_d     = 1'b0;
    dly_we_c  = 1'b0;
    cerr_d    = bus.coef_we && (state_q != IDLE);
    coef_we_c = bus.coef_we && (state_q == IDLE) && (32'(bus.coef_addr) < NUM_TAPS);
    rs_c      = round_sat(wide_t'(acc_q), COEF_FRAC, DATA_WIDTH);
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in && ready_q && (32'(bus.ch_in) < NUM_CH)) begin
          dly_we_c = 1'b1;
          ch_d     = bus.ch_in;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        k_d   = k_q + ADDR_W'(1);
        if (32'(k_q) == NUM_TAPS - 1) state_d = DONE;
      end
      DONE: begin
        filt_d         = DATA_WIDTH'(rs_c.val);
        sat_d          = rs_c.clip;
        ch_out_d       = ch_q;
        drdy_d         = 1'b1;
        wptr_d[ch_q]   = (32'(wptr_q[ch_q]) == NUM_TAPS - 1) ? '0 : wptr_q[ch_q] + ADDR_W'(1);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  assign unused_rs_c = ^rs_c.val[WIDE_W-1:DATA_WIDTH];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ch_q     <= '0;
      acc_q    <= '0;
      filt_q   <= '0;
      ch_out_q <= '0;
      ready_q  <= 1'b1;
      drdy_q   <= 1'b0;
      sat_q    <= 1'b0;
      cerr_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) wptr_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      filt_q   <= filt_d;
      ch_out_q <= ch_out_d;
      ready_q  <= ready_d;
      drdy_q   <= drdy_d;
      sat_q    <= sat_d;
      cerr_q   <= cerr_d;
      wptr_q   <= wptr_d;
    end
  end

  // Delay-line memory: one write per accepted sample, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < NUM_TAPS; t++) delay_mem[c][t] <= '0;
    end else if (dly_we_c) begin
      delay_mem[bus.ch_in][wptr_q[bus.ch_in]] <= bus.audio_in;
    end
  end

  assign bus.ready_out      = ready_q;
  assign bus.coef_err       = cerr_q;
  assign bus.filtered_audio = filt_q;
  assign bus.ch_out         = ch_out_q;
  assign bus.data_ready     = drdy_q;
  assign bus.sat_out        = sat_q;
endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc: directed scenarios plus randomized traffic
// compared against a newest-first history model of the filter.
module tb_fir_filter_mc;
  localparam int unsigned NT   = 29;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned CF   = 14;
  localparam int unsigned NCH  = 2;
  localparam int unsigned CH_W = 1;
  localparam int unsigned AW   = 5;
  localparam int          LAT  = NT + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_filter_mc_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .NUM_CH(NCH)) bus ();

  fir_filter_mc #(.NUM_TAPS(NT), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(CF),
                  .NUM_CH(NCH)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int m_coef [NT];
  int m_hist [NCH][NT];

  function automatic void m_reset();
    for (int i = 0; i < NT; i++) m_coef[i] = (i == 0) ? (1 << CF) : 0;
    for (int c = 0; c < NCH; c++) for (int i = 0; i < NT; i++) m_hist[c][i] = 0;
  endfunction

  // y = round_half_up(sum(coef[i] * x[n-i]) / 2^CF), clipped to DW bits.
  function automatic void m_push(input int ch, input int x, output int y, output bit sat);
    longint acc, n, q;
    for (int i = NT - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
    m_hist[ch][0] = x;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(m_coef[i]) * longint'(m_hist[ch][i]);
    n = acc + (longint'(1) << (CF - 1));
    q = n / (longint'(1) << CF);
    if ((n % (longint'(1) << CF)) != 0 && n < 0) q -= 1;
    sat = 1'b0;
    if (q > 32767)  begin q = 32767;  sat = 1'b1; end
    if (q < -32768) begin q = -32768; sat = 1'b1; end
    y = int'(q);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(addr); bus.coef_data = CW'(data);
    @(posedge clk);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (addr < int'(NT)) m_coef[addr] = data;
  endtask

  // Called at a negedge with the block idle; returns at the negedge where data_ready is seen.
  task automatic run_sample(input int ch, input int x, input bit we, input int addr,
                            input int data, output int y, output int ych, output bit sat,
                            output int lat);
    bus.valid_in = 1'b1; bus.ch_in = CH_W'(ch); bus.audio_in = DW'(x);
    bus.coef_we = we; bus.coef_addr = AW'(addr); bus.coef_data = CW'(data);
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0; bus.coef_we = 1'b0;
    lat = 1;
    while (bus.data_ready !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    y = int'(bus.filtered_audio); ych = int'(bus.ch_out); sat = bus.sat_out;
  endtask

  task automatic load_boxcar();
    for (int i = 0; i < int'(NT); i++) write_coef(i, (i < 4) ? 4096 : 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.filtered_audio, bus.ch_out, bus.data_ready, bus.sat_out, bus.coef_err} !== '0)
      $display("FAIL reset_outputs: got fa=%0d ch=%0d dr=%b sat=%b err=%b expected all 0",
               bus.filtered_audio, bus.ch_out, bus.data_ready, bus.sat_out, bus.coef_err);
    else n_pass++;
    n_checks++;
    if (bus.ready_out !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready_out);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int xs[3] = '{1000, 0, 0};
    int y, ych, lat, ey;
    bit sat, es;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m_push(0, xs[i], ey, es);
      run_sample(0, xs[i], 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== xs[i] || ych !== 0 || sat !== 1'b0)
        $display("FAIL impulse_%0d: got y=%0d ch=%0d sat=%b expected y=%0d ch=0 sat=0",
                 i, y, ych, sat, xs[i]);
      else n_pass++;
      n_checks++;
      if (lat !== LAT) $display("FAIL impulse_lat_%0d: got %0d expected %0d", i, lat, LAT);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL dr_pulse: got %b expected 0", bus.data_ready);
    else n_pass++;
  endtask

  task automatic test_boxcar();
    int y, ych, lat;
    bit sat;
    do_reset();
    load_boxcar();
    for (int i = 1; i <= 4; i++) begin
      run_sample(0, 400, 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== 100 * i || ych !== 0 || lat !== LAT)
        $display("FAIL boxcar_%0d: got y=%0d ch=%0d lat=%0d expected y=%0d ch=0 lat=%0d",
                 i, y, ych, lat, 100 * i, LAT);
      else n_pass++;
    end
  endtask

  task automatic test_rounding();
    int xs[3] = '{3, -3, 1};
    int ex[3] = '{2, -1, 1};
    int y, ych, lat;
    bit sat;
    do_reset();
    write_coef(0, 8192);
    for (int i = 0; i < 3; i++) begin
      run_sample(0, xs[i], 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== ex[i]) $display("FAIL round_%0d: got %0d expected %0d", i, y, ex[i]);
      else n_pass++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (int'(bus.filtered_audio) !== 1)
      $display("FAIL round_hold: got %0d expected 1", bus.filtered_audio);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int y, ych, lat;
    bit sat;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      write_coef(0, 16383);
      write_coef(1, 16383);
      run_sample(0, s ? -30000 : 30000, 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (sat !== 1'b0) $display("FAIL sat_first_%0d: got sat=%b expected 0", s, sat);
      else n_pass++;
      run_sample(0, s ? -30000 : 30000, 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== (s ? -32768 : 32767) || sat !== 1'b1)
        $display("FAIL sat_second_%0d: got y=%0d sat=%b expected y=%0d sat=1",
                 s, y, sat, s ? -32768 : 32767);
      else n_pass++;
    end
  endtask

  task automatic test_channels();
    int y, ych, lat;
    bit sat;
    do_reset();
    load_boxcar();
    for (int i = 1; i <= 4; i++) begin
      run_sample(0, 400, 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== 100 * i || ych !== 0)
        $display("FAIL chan0_%0d: got y=%0d ch=%0d expected y=%0d ch=0", i, y, ych, 100 * i);
      else n_pass++;
      run_sample(1, -800, 1'b0, 0, 0, y, ych, sat, lat);
      n_checks++;
      if (y !== -200 * i || ych !== 1)
        $display("FAIL chan1_%0d: got y=%0d ch=%0d expected y=%0d ch=1", i, y, ych, -200 * i);
      else n_pass++;
    end
  endtask

  task automatic test_coef_err();
    int y, ych, lat;
    bit sat;
    do_reset();
    bus.valid_in = 1'b1; bus.ch_in = CH_W'(1); bus.audio_in = DW'(1234);
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.coef_we = 1'b1; bus.coef_addr = AW'(0); bus.coef_data = CW'(0);
    @(posedge clk);
    @(negedge clk);
    bus.coef_we = 1'b0;
    n_checks++;
    if (bus.coef_err !== 1'b1) $display("FAIL coef_err_pulse: got %b expected 1", bus.coef_err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.coef_err !== 1'b0) $display("FAIL coef_err_clear: got %b expected 0", bus.coef_err);
    else n_pass++;
    lat = 0;
    while (bus.data_ready !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_checks++;
    if (int'(bus.filtered_audio) !== 1234 || int'(bus.ch_out) !== 1)
      $display("FAIL coef_err_result: got y=%0d ch=%0d expected y=1234 ch=1",
               bus.filtered_audio, bus.ch_out);
    else n_pass++;
    run_sample(0, 777, 1'b0, 0, 0, y, ych, sat, lat);
    n_checks++;
    if (y !== 777) $display("FAIL coef_err_kept: got %0d expected 777", y);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mac();
    int y, ych, lat, seen;
    bit sat;
    do_reset();
    write_coef(0, 4096);
    bus.valid_in = 1'b1; bus.ch_in = CH_W'(0); bus.audio_in = DW'(5000);
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.data_ready !== 1'b0)
      $display("FAIL midrst_state: got ready=%b dr=%b expected ready=1 dr=0",
               bus.ready_out, bus.data_ready);
    else n_pass++;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.data_ready === 1'b1) seen++; end
    n_checks++;
    if (seen !== 0) $display("FAIL midrst_no_output: got %0d pulses expected 0", seen);
    else n_pass++;
    run_sample(0, 1000, 1'b0, 0, 0, y, ych, sat, lat);
    n_checks++;
    if (y !== 1000) $display("FAIL midrst_identity: got %0d expected 1000", y);
    else n_pass++;
  endtask

  // Back-to-back random traffic, with occasional same-cycle coefficient writes.
  task automatic test_random();
    int y, ych, lat, ey, ch, x, addr, data;
    bit sat, es, we;
    do_reset();
    for (int i = 0; i < int'(NT); i++) write_coef(i, int'($urandom_range(0, 8192)) - 4096);
    for (int n = 0; n < 40; n++) begin
      ch   = int'($urandom_range(0, NCH - 1));
      x    = int'($urandom_range(0, 65535)) - 32768;
      we   = ($urandom_range(0, 3) == 0);
      addr = int'($urandom_range(0, 31));
      data = int'($urandom_range(0, 16384)) - 8192;
      if (we && addr < int'(NT)) m_coef[addr] = data;
      m_push(ch, x, ey, es);
      run_sample(ch, x, we, addr, data, y, ych, sat, lat);
      n_checks++;
      if (y !== ey || ych !== ch || sat !== es)
        $display("FAIL random_%0d: got y=%0d ch=%0d sat=%b expected y=%0d ch=%0d sat=%b",
                 n, y, ych, sat, ey, ch, es);
      else n_pass++;
      n_checks++;
      if (lat !== LAT) $display("FAIL random_lat_%0d: got %0d expected %0d", n, lat, LAT);
      else n_pass++;
    end
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.ch_in = '0; bus.audio_in = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    m_reset();
    test_reset();
    test_impulse();
    test_boxcar();
    test_rounding();
    test_saturation();
    test_channels();
    test_coef_err();
    test_reset_mid_mac();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
